// File: rtl/serial2parallel_if.sv
// Beat-in / word-out bundle for serial2parallel. The master drives input beats and the abort.
// The slave presents the assembled word strobe.
interface serial2parallel_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_NUM_I  = 1,
  parameter int BUS_NUM_O  = 8
);
  logic                                  clear_i;
  logic                                  data_valid_i;
  logic                                  data_last_i;
  logic [BUS_NUM_I-1:0][DATA_WIDTH-1:0]  data_i;
  logic                                  data_valid_o;
  logic                                  data_last_o;
  logic [BUS_NUM_O-1:0]                  data_mask_o;
  logic [BUS_NUM_O-1:0][DATA_WIDTH-1:0]  data_o;

  modport master (
    output clear_i, data_valid_i, data_last_i, data_i,
    input  data_valid_o, data_last_o, data_mask_o, data_o
  );

  modport slave (
    input  clear_i, data_valid_i, data_last_i, data_i,
    output data_valid_o, data_last_o, data_mask_o, data_o
  );
endinterface

// File: rtl/serial2parallel.sv
// Deserialiser: gathers RATIO narrow beats into one wide word and emits it as a single-cycle strobe.
// Lane placement is the inverse of parallel2serial, so beat k / lane j lands at wide lane k + RATIO*j.
module serial2parallel #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_NUM_I  = 1,
  parameter int BUS_NUM_O  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  serial2parallel_if.slave      bus
);

  localparam int RATIO = BUS_NUM_O / BUS_NUM_I;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int AW    = (BUS_NUM_O > 1) ? $clog2(BUS_NUM_O) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

  if (((BUS_NUM_O % BUS_NUM_I) != 0) || (RATIO < 2)) begin : g_param_check
    $error("serial2parallel: BUS_NUM_O must be a multiple of BUS_NUM_I with a ratio of at least 2");
  end

  logic [CW-1:0]                         r_cnt;
  logic [BUS_NUM_O-1:0][DATA_WIDTH-1:0]  r_buf;
  logic [BUS_NUM_O-1:0]                  r_mask;
  logic [BUS_NUM_O-1:0][DATA_WIDTH-1:0]  w_buf_next;
  logic [BUS_NUM_O-1:0]                  w_mask_next;
  logic                                  w_accept;
  logic                                  w_emit;

  logic                                  r_valid_o;
  logic                                  r_last_o;
  logic [BUS_NUM_O-1:0]                  r_mask_o;
  logic [BUS_NUM_O-1:0][DATA_WIDTH-1:0]  r_data_o;

  function automatic logic [AW-1:0] lane_idx(input logic [CW-1:0] k, input int j);
    return AW'(k) + AW'(RATIO * j);
  endfunction

  // Beat acceptance and word-completion decode; abort outranks any beat.
  always_comb begin
    w_accept = 1'b0;
    w_emit   = 1'b0;
    if (bus.data_valid_i && !bus.clear_i) begin
      w_accept = 1'b1;
      w_emit   = (r_cnt == CNT_LAST) || bus.data_last_i;
    end else begin
      w_accept = 1'b0;
      w_emit   = 1'b0;
    end
  end

  // Assembly buffer as it would look with the current beat merged in.
  always_comb begin
    w_buf_next  = r_buf;
    w_mask_next = r_mask;
    if (w_accept) begin
      for (int j = 0; j < BUS_NUM_I; j++) begin
        w_buf_next[lane_idx(r_cnt, j)]  = bus.data_i[j];
        w_mask_next[lane_idx(r_cnt, j)] = 1'b1;
      end
    end else begin
      w_buf_next  = r_buf;
      w_mask_next = r_mask;
    end
  end

  // Assembly state: restart from empty after an emitted word or an abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_buf  <= '0;
      r_mask <= '0;
    end else if (bus.clear_i || w_emit) begin
      r_cnt  <= '0;
      r_buf  <= '0;
      r_mask <= '0;
    end else if (w_accept) begin
      r_cnt  <= r_cnt + CW'(1);
      r_buf  <= w_buf_next;
      r_mask <= w_mask_next;
    end else begin
      r_cnt  <= r_cnt;
      r_buf  <= r_buf;
      r_mask <= r_mask;
    end
  end

  // Output word register, independent of the buffer so full-rate input never stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid_o <= 1'b0;
      r_last_o  <= 1'b0;
      r_mask_o  <= '0;
      r_data_o  <= '0;
    end else if (w_emit) begin
      r_valid_o <= 1'b1;
      r_last_o  <= bus.data_last_i;
      r_mask_o  <= w_mask_next;
      r_data_o  <= w_buf_next;
    end else begin
      r_valid_o <= 1'b0;
      r_last_o  <= r_last_o;
      r_mask_o  <= r_mask_o;
      r_data_o  <= r_data_o;
    end
  end

  assign bus.data_valid_o = r_valid_o;
  assign bus.data_last_o  = r_last_o;
  assign bus.data_mask_o  = r_mask_o;
  assign bus.data_o       = r_data_o;

endmodule
